// File: rtl/core_param.sv
`default_nettype none
// ============================================================================
//  Module   : core_param
//  Purpose  : Parametrised shader core. 16-bit instructions
//             (op[15:12] a[11:8] b[7:4] t[3:0]), sixteen DW-bit registers and
//             one req/ready memory port shared by fetch, load and store.
//             SPWN and SYNC block until the core array accepts or releases.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst              clock; asynchronous active-high reset
//    core_id               static core index (debug tag only, not used)
//    enable                0 freezes state and drops every request
//    do_next_ins           scheduler lets the fetched instruction issue
//    next_ins_ready        core is in FETCH and enabled
//    overwrite, new_pc     restart at new_pc in FETCH (beats enable)
//    halted                core is in HALT
//    mem_req/we/addr/wdata memory request; completes on mem_req & mem_ready
//    mem_ready, mem_rdata  handshake and same-cycle read data
//    spawn_valid/id/pc     SPWN request, held until spawn_ready
//    sync_req/group        barrier wait, held until sync_release
//  Opcodes
//    0 NOP  1 MOV  2 ADD  3 JMP  4 JEQ  5 JLT  6 JGT  7 LD  8 LDR
//    9 ST  10 SPWN  11 SYNC  12 HALT  13-15 behave as NOP
//    Immediates: MOV/LD ii = inst[11:4], ST ss = inst[7:0] (data = regs[a]),
//    JMP jjj = inst[11:0], branch offset = t, SPWN id = inst[11:8],
//    pc = inst[7:0], SYNC group = inst[11:0].
//  DW must be >= 16 and AW >= 12.
// ============================================================================
module core_param #(
    parameter int DW   = 16,
    parameter int AW   = 16,
    parameter int ID_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ID_W-1:0] core_id,
    input  logic            enable,
    input  logic            do_next_ins,
    output logic            next_ins_ready,
    input  logic            overwrite,
    input  logic [AW-1:0]   new_pc,
    output logic            halted,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata,
    output logic            spawn_valid,
    output logic [3:0]      spawn_id,
    output logic [AW-1:0]   spawn_pc,
    input  logic            spawn_ready,
    output logic            sync_req,
    output logic [11:0]     sync_group,
    input  logic            sync_release
);

    localparam logic [3:0] c_OP_NOP  = 4'd0;
    localparam logic [3:0] c_OP_MOV  = 4'd1;
    localparam logic [3:0] c_OP_ADD  = 4'd2;
    localparam logic [3:0] c_OP_JMP  = 4'd3;
    localparam logic [3:0] c_OP_JEQ  = 4'd4;
    localparam logic [3:0] c_OP_JLT  = 4'd5;
    localparam logic [3:0] c_OP_JGT  = 4'd6;
    localparam logic [3:0] c_OP_LD   = 4'd7;
    localparam logic [3:0] c_OP_LDR  = 4'd8;
    localparam logic [3:0] c_OP_ST   = 4'd9;
    localparam logic [3:0] c_OP_SPWN = 4'd10;
    localparam logic [3:0] c_OP_SYNC = 4'd11;
    localparam logic [3:0] c_OP_HALT = 4'd12;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_LOAD  = 3'd2,
        S_STORE = 3'd3,
        S_SPAWN = 3'd4,
        S_SYNCW = 3'd5,
        S_HALT  = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   inst_q, inst_d;
    logic [DW-1:0] regs_q [16];

    // The core index only tags debug messages in simulation models.
    logic w_unused_core_id;
    assign w_unused_core_id = ^core_id;

    // ------------------------------------------------------------------
    // Decode. Everything derives from inst_q and the register file, which
    // cannot change while a request waits, so a held request is re-derived
    // each cycle and stays bit-identical across stalls and enable gaps.
    // ------------------------------------------------------------------
    logic [3:0]    w_op, w_a, w_b, w_t;
    logic [DW-1:0] w_ra, w_rb, w_sum;
    logic [AW-1:0] w_pc_inc, w_pc_br, w_ld_addr, w_st_addr;

    assign w_op      = inst_q[15:12];
    assign w_a       = inst_q[11:8];
    assign w_b       = inst_q[7:4];
    assign w_t       = inst_q[3:0];
    assign w_ra      = regs_q[w_a];
    assign w_rb      = regs_q[w_b];
    assign w_sum     = w_ra + w_rb;
    assign w_pc_inc  = pc_q + AW'(1);
    assign w_pc_br   = pc_q + AW'(w_t);
    assign w_ld_addr = (w_op == c_OP_LDR) ? AW'(w_sum) : AW'(inst_q[11:4]);
    assign w_st_addr = AW'(inst_q[7:0]);

    logic          w_reg_we;
    logic [DW-1:0] w_reg_wdata;
    logic          w_req, w_we, w_spawn, w_sync, w_next_rdy, w_halted;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        w_reg_we    = 1'b0;
        w_reg_wdata = '0;
        w_req       = 1'b0;
        w_we        = 1'b0;
        w_addr      = pc_q;
        w_wdata     = '0;
        w_spawn     = 1'b0;
        w_sync      = 1'b0;
        w_next_rdy  = 1'b0;
        w_halted    = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                w_req      = 1'b1;
                w_next_rdy = 1'b1;
                // A ready without issue permission is dropped; fetch retries.
                if (mem_ready && do_next_ins) begin
                    inst_d  = mem_rdata[15:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = w_pc_inc;
                case (w_op)
                    c_OP_MOV: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = DW'(inst_q[11:4]);
                    end
                    c_OP_ADD: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = w_sum;
                    end
                    c_OP_JMP: pc_d = AW'(inst_q[11:0]);
                    c_OP_JEQ: if (w_ra == w_rb) pc_d = w_pc_br;
                    c_OP_JLT: if (w_ra <  w_rb) pc_d = w_pc_br;
                    c_OP_JGT: if (w_ra >  w_rb) pc_d = w_pc_br;
                    c_OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    c_OP_LD, c_OP_LDR: begin
                        w_req  = 1'b1;
                        w_addr = w_ld_addr;
                        if (mem_ready) begin
                            w_reg_we    = 1'b1;
                            w_reg_wdata = mem_rdata;
                        end else begin
                            state_d = S_LOAD;
                            pc_d    = pc_q;
                        end
                    end
                    c_OP_ST: begin
                        w_req   = 1'b1;
                        w_we    = 1'b1;
                        w_addr  = w_st_addr;
                        w_wdata = w_ra;
                        if (!mem_ready) begin
                            state_d = S_STORE;
                            pc_d    = pc_q;
                        end
                    end
                    c_OP_SPWN: begin
                        w_spawn = 1'b1;
                        if (!spawn_ready) begin
                            state_d = S_SPAWN;
                            pc_d    = pc_q;
                        end
                    end
                    c_OP_SYNC: begin
                        w_sync = 1'b1;
                        if (!sync_release) begin
                            state_d = S_SYNCW;
                            pc_d    = pc_q;
                        end
                    end
                    default: ;  // NOP and unassigned opcodes: pc+1 only
                endcase
            end
            S_LOAD: begin
                w_req  = 1'b1;
                w_addr = w_ld_addr;
                if (mem_ready) begin
                    w_reg_we    = 1'b1;
                    w_reg_wdata = mem_rdata;
                    pc_d        = w_pc_inc;
                    state_d     = S_FETCH;
                end
            end
            S_STORE: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = w_st_addr;
                w_wdata = w_ra;
                if (mem_ready) begin
                    pc_d    = w_pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_SPAWN: begin
                w_spawn = 1'b1;
                if (spawn_ready) begin
                    pc_d    = w_pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_SYNCW: begin
                w_sync = 1'b1;
                if (sync_release) begin
                    pc_d    = w_pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALT: w_halted = 1'b1;
            default: state_d = S_FETCH;
        endcase

        // Disabled: nothing advances; requests are masked at the outputs.
        if (!enable) begin
            state_d  = state_q;
            pc_d     = pc_q;
            inst_d   = inst_q;
            w_reg_we = 1'b0;
        end

        // Restart beats enable and abandons any wait without a write.
        if (overwrite) begin
            state_d  = S_FETCH;
            pc_d     = new_pc;
            w_reg_we = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            inst_q  <= '0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            if (w_reg_we) begin
                regs_q[w_t] <= w_reg_wdata;
            end
        end
    end

    // The reset state is FETCH, which would otherwise request immediately;
    // the rst term keeps every output quiet while reset is applied. The
    // other outputs are already zero from the cleared registers.
    assign mem_req        = ~rst & enable & w_req;
    assign next_ins_ready = ~rst & enable & w_next_rdy;
    assign spawn_valid    = ~rst & enable & w_spawn;
    assign sync_req       = ~rst & enable & w_sync;
    assign halted         = ~rst & w_halted;
    assign mem_we         = w_we;
    assign mem_addr       = w_addr;
    assign mem_wdata      = w_wdata;
    assign spawn_id       = inst_q[11:8];
    assign spawn_pc       = AW'(inst_q[7:0]);
    assign sync_group     = inst_q[11:0];

endmodule
`default_nettype wire
